// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter that shares the single-ported unified memory between
// instruction fetch (I) and the load/store path (D), one transaction at a time.
module mem_port_arbiter #(
    parameter int ADDR_W  = 16,
    parameter int DATA_W  = 16,
    parameter int MEM_LAT = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic              if_ack,
    output logic [DATA_W-1:0] if_rdata,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic              d_ack,
    output logic [DATA_W-1:0] d_rdata,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              busy
);

    typedef enum logic [1:0] {IDLE, ACCESS, WAIT, DONE} state_t;

    localparam logic [3:0] LAT4 = 4'(MEM_LAT);

    state_t            state, state_nxt;
    logic              own_d;      // 1 = current transaction belongs to D
    logic              last_d;     // 1 = D was the last requester acknowledged
    logic              lat_we;
    logic [ADDR_W-1:0] lat_addr;
    logic [DATA_W-1:0] lat_wdata;
    logic [3:0]        cnt;
    logic              grant_d;

    // D wins when it is alone, or when both ask and I was served last.
    assign grant_d = d_req && (!if_req || !last_d);

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (if_req || d_req) state_nxt = ACCESS;
            ACCESS:  state_nxt = WAIT;
            WAIT:    if (cnt == 4'd1) state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            own_d     <= 1'b0;
            last_d    <= 1'b1;
            lat_we    <= 1'b0;
            lat_addr  <= '0;
            lat_wdata <= '0;
            cnt       <= '0;
            if_rdata  <= '0;
            d_rdata   <= '0;
        end else begin
            state <= state_nxt;
            case (state)
                IDLE: begin
                    if (if_req || d_req) begin
                        own_d     <= grant_d;
                        lat_we    <= grant_d && d_we;
                        lat_addr  <= grant_d ? d_addr : if_addr;
                        lat_wdata <= grant_d ? d_wdata : '0;
                    end
                end
                ACCESS: cnt <= LAT4;
                WAIT: begin
                    cnt <= cnt - 4'd1;
                    if (cnt == 4'd1 && !lat_we) begin
                        if (own_d) d_rdata  <= mem_rdata;
                        else       if_rdata <= mem_rdata;
                    end
                end
                DONE: last_d <= own_d;
                default: ;
            endcase
        end
    end

    // Memory-side outputs are forced to zero outside the access cycle.
    always_comb begin
        mem_en    = (state == ACCESS);
        mem_we    = mem_en && lat_we;
        mem_addr  = mem_en ? lat_addr : '0;
        mem_wdata = mem_en ? lat_wdata : '0;
        if_ack    = (state == DONE) && !own_d;
        d_ack     = (state == DONE) && own_d;
        busy      = (state != IDLE);
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: directed scenarios, then random fetch/load/store
// traffic checked against a transaction-level requester and memory model.
module tb_mem_port_arbiter;

    localparam int LAT = 2;

    logic        clk = 1'b0;
    logic        rst;
    logic        if_req, d_req, d_we;
    logic [15:0] if_addr, d_addr, d_wdata;
    logic        if_ack, d_ack, mem_en, mem_we, busy;
    logic [15:0] if_rdata, d_rdata, mem_addr, mem_wdata, mem_rdata;

    logic        b_if_req, b_d_req, b_d_we;
    logic [15:0] b_if_addr, b_d_addr, b_d_wdata;
    logic        b_if_ack, b_d_ack, b_mem_en, b_mem_we, b_busy;
    logic [15:0] b_if_rdata, b_d_rdata, b_mem_addr, b_mem_wdata, b_mem_rdata;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    mem_port_arbiter #(.ADDR_W(16), .DATA_W(16), .MEM_LAT(LAT)) u_dut (
        .clk(clk), .rst(rst),
        .if_req(if_req), .if_addr(if_addr), .if_ack(if_ack), .if_rdata(if_rdata),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_ack(d_ack), .d_rdata(d_rdata),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .busy(busy)
    );

    mem_port_arbiter #(.ADDR_W(16), .DATA_W(16), .MEM_LAT(1)) u_dut1 (
        .clk(clk), .rst(rst),
        .if_req(b_if_req), .if_addr(b_if_addr), .if_ack(b_if_ack), .if_rdata(b_if_rdata),
        .d_req(b_d_req), .d_we(b_d_we), .d_addr(b_d_addr), .d_wdata(b_d_wdata),
        .d_ack(b_d_ack), .d_rdata(b_d_rdata),
        .mem_en(b_mem_en), .mem_we(b_mem_we), .mem_addr(b_mem_addr), .mem_wdata(b_mem_wdata),
        .mem_rdata(b_mem_rdata), .busy(b_busy)
    );

    // Memory model: unwritten words read as a fixed pattern of their address.
    logic [15:0] mem [256];
    bit          wv  [256];
    logic [15:0] rp  [LAT];
    logic [15:0] rp1;

    function automatic logic [15:0] pat(input logic [7:0] a);
        return {a, a} ^ 16'hE5E5;
    endfunction

    function automatic logic [15:0] rd(input logic [15:0] a);
        return wv[a[7:0]] ? mem[a[7:0]] : pat(a[7:0]);
    endfunction

    always @(posedge clk) begin
        if (mem_en && mem_we) begin
            mem[mem_addr[7:0]] <= mem_wdata;
            wv[mem_addr[7:0]]  <= 1'b1;
        end
        rp[0] <= (mem_en && !mem_we) ? rd(mem_addr) : 16'($urandom);
        for (int i = 1; i < LAT; i++) rp[i] <= rp[i-1];
        rp1 <= (b_mem_en && !b_mem_we) ? pat(b_mem_addr[7:0]) : 16'($urandom);
    end

    assign mem_rdata   = rp[LAT-1];
    assign b_mem_rdata = rp1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        if_req = 0; d_req = 0; d_we = 0; if_addr = 0; d_addr = 0; d_wdata = 0;
        step();
        step();
        rst = 1'b0;
    endtask

    // random-phase requester state
    bit          i_pend, d_pend, dwe;
    logic [15:0] ia, da, dwd, exp_if, exp_d, en_addr, en_wd;
    logic        en_we;
    int          iw, dw, cyc, en_cyc;

    initial begin
        b_if_req = 0; b_if_addr = 0; b_d_req = 0; b_d_we = 0; b_d_addr = 0; b_d_wdata = 0;
        do_reset();
        chk("rst_busy", busy, 0);
        chk("rst_outs", {if_ack, d_ack, mem_en, mem_we}, 0);
        chk("rst_mem", {mem_addr, mem_wdata}, 0);
        chk("rst_rdata", {if_rdata, d_rdata}, 0);

        // 1: single fetch
        if_req = 1; if_addr = 16'h0040;
        step(); chk("t1_en", {mem_en, mem_we}, 2'b10); chk("t1_addr", mem_addr, 16'h0040);
        step(); chk("t1_en_c2", mem_en, 0);
        step(); chk("t1_rdata_c3", mem_rdata, 16'hA5A5); chk("t1_noack", if_ack, 0);
        step(); chk("t1_ack", {if_ack, d_ack}, 2'b10); chk("t1_data", if_rdata, 16'hA5A5);
        if_req = 0;
        step(); chk("t1_idle", {busy, if_ack}, 0);

        // 2: store
        d_req = 1; d_we = 1; d_addr = 16'h1234; d_wdata = 16'hBEEF;
        step(); chk("t2_en", {mem_en, mem_we}, 2'b11);
        chk("t2_aw", {mem_addr, mem_wdata}, 32'h1234BEEF);
        step(); step();
        step(); chk("t2_ack", {if_ack, d_ack}, 2'b01); chk("t2_rdata", d_rdata, 0);
        d_req = 0; d_we = 0;
        step();

        // 3: contention right after reset, I goes first
        do_reset();
        if_req = 1; if_addr = 16'h0011; d_req = 1; d_addr = 16'h0022;
        step(); chk("t3_i_en", {mem_en, mem_addr}, {1'b1, 16'h0011});
        step(); step();
        step(); chk("t3_i_ack", {if_ack, d_ack}, 2'b10); chk("t3_i_data", if_rdata, rd(16'h0011));
        if_req = 0;
        step(); chk("t3_c5_busy", busy, 0);
        step(); chk("t3_d_en", {mem_en, mem_we, mem_addr}, {2'b10, 16'h0022});
        step(); step();
        step(); chk("t3_d_ack", {if_ack, d_ack}, 2'b01); chk("t3_d_data", d_rdata, rd(16'h0022));
        d_req = 0;
        step();

        // 4: both held, grants alternate I,D,I,D
        if_req = 1; if_addr = 16'h0100; d_req = 1; d_addr = 16'h0200;
        for (int k = 0; k < 4; k++) begin
            repeat ((k == 0) ? 4 : 5) step();
            chk($sformatf("t4_ack%0d", k), {if_ack, d_ack}, (k % 2 == 0) ? 2'b10 : 2'b01);
            if (k % 2 == 0) if_addr = if_addr + 16'd1;
            else            d_addr  = d_addr + 16'd1;
        end
        if_req = 0; d_req = 0;
        step();

        // 5: reset mid-transaction drops the access
        step();
        if_req = 1; if_addr = 16'h0055;
        step(); step();
        rst = 1;
        step(); rst = 0;
        chk("t5_c3", {mem_en, busy, if_ack, d_ack}, 0); chk("t5_rdata", if_rdata, 0);
        step(); chk("t5_reserve", {mem_en, mem_addr}, {1'b1, 16'h0055});
        step(); chk("t5_noack", {if_ack, d_ack}, 0);
        step(); step(); chk("t5_ack", if_ack, 1); chk("t5_data", if_rdata, rd(16'h0055));
        if_req = 0;

        // 6: MEM_LAT=1 load
        b_d_req = 1; b_d_addr = 16'h0077;
        step(); chk("t6_en", {b_mem_en, b_mem_we}, 2'b10);
        step(); chk("t6_noack", b_d_ack, 0);
        step(); chk("t6_ack", {b_if_ack, b_d_ack}, 2'b01); chk("t6_data", b_d_rdata, pat(8'h77));
        b_d_req = 0;
        step(); chk("t6_idle", b_busy, 0);

        // random traffic
        do_reset();
        i_pend = 0; d_pend = 0; exp_if = 0; exp_d = 0; iw = 0; dw = 0; cyc = 0; en_cyc = -100;
        en_addr = 0; en_wd = 0; en_we = 0; ia = 0; da = 0; dwd = 0; dwe = 0;
        repeat (3000) begin
            step();
            cyc++;
            if (mem_en) begin
                en_cyc = cyc; en_addr = mem_addr; en_we = mem_we; en_wd = mem_wdata;
            end
            if (if_ack && d_ack) chk("r_ack_excl", {if_ack, d_ack}, 2'b00);
            if (if_ack) begin
                chk("r_i_grant", i_pend, 1);
                chk("r_i_lat", cyc - en_cyc, LAT + 1);
                chk("r_i_req", {en_we, en_addr}, {1'b0, ia});
                exp_if = rd(ia);
                i_pend = 0;
            end
            if (d_ack) begin
                chk("r_d_grant", d_pend, 1);
                chk("r_d_lat", cyc - en_cyc, LAT + 1);
                chk("r_d_req", {en_we, en_addr}, {dwe, da});
                if (dwe) chk("r_d_wdata", en_wd, dwd);
                else     exp_d = rd(da);
                d_pend = 0;
            end
            if (if_rdata !== exp_if) chk("r_if_rdata", if_rdata, exp_if);
            if (d_rdata !== exp_d)   chk("r_d_rdata", d_rdata, exp_d);
            if (i_pend && ++iw > 3 * (LAT + 3)) begin chk("r_i_starve", iw, 0); i_pend = 0; end
            if (d_pend && ++dw > 3 * (LAT + 3)) begin chk("r_d_starve", dw, 0); d_pend = 0; end
            if (!i_pend && $urandom_range(1, 0) == 1) begin
                i_pend = 1; ia = 16'($urandom); iw = 0;
            end
            if (!d_pend && $urandom_range(1, 0) == 1) begin
                d_pend = 1; da = 16'($urandom); dwd = 16'($urandom);
                dwe = 1'($urandom_range(1, 0)); dw = 0;
            end
            if_req = i_pend; if_addr = ia;
            d_req = d_pend; d_addr = da; d_we = dwe; d_wdata = dwd;
        end
        chk("r_end_rdata", {if_rdata, d_rdata}, {exp_if, exp_d});

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
